// File: rtl/cache_fill_controller_if.sv
// CPU load port, cache and word-wide memory signals seen by the fill controller.
// master = controller side, slave = CPU/cache/memory side.
interface cache_fill_controller_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned WORD_W = 32,
   parameter int unsigned CNT_W  = 16
);
   logic                  cpu_req;
   logic [ADDR_W-1:0]     cpu_adr;
   logic                  cpu_busy;
   logic                  cpu_ready;
   logic [WORD_W-1:0]     cpu_data;
   logic [ADDR_W-1:0]     cache_adr;
   logic                  cache_hit;
   logic [WORD_W-1:0]     cache_rdata;
   logic                  cache_write;
   logic [4*WORD_W-1:0]   cache_wblock;
   logic                  mem_req;
   logic [ADDR_W-1:0]     mem_adr;
   logic                  mem_ready;
   logic [WORD_W-1:0]     mem_data;
   logic [CNT_W-1:0]      hit_count;
   logic [CNT_W-1:0]      miss_count;

   modport master (
      input  cpu_req, cpu_adr, cache_hit, cache_rdata, mem_ready, mem_data,
      output cpu_busy, cpu_ready, cpu_data, cache_adr, cache_write, cache_wblock,
             mem_req, mem_adr, hit_count, miss_count
   );

   modport slave (
      output cpu_req, cpu_adr, cache_hit, cache_rdata, mem_ready, mem_data,
      input  cpu_busy, cpu_ready, cpu_data, cache_adr, cache_write, cache_wblock,
             mem_req, mem_adr, hit_count, miss_count
   );
endinterface

// File: rtl/cache_fill_controller.sv
// Direct-mapped cache lookup with 4-word block refill from word-wide memory
// and saturating hit/miss counters.
module cache_fill_controller #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned WORD_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input logic                    clk,
   input logic                    rst,
   cache_fill_controller_if.master bus
);

   typedef enum logic [1:0] {StIdle, StLookup, StFill, StWrite} state_e;

   state_e                   state_q, state_d;
   logic [ADDR_W-1:0]        adr_q, adr_d;
   logic [1:0]               fill_cnt_q, fill_cnt_d;
   logic [3:0][WORD_W-1:0]   fill_buf_q, fill_buf_d;
   logic                     cpu_ready_q, cpu_ready_d;
   logic [WORD_W-1:0]        cpu_data_q, cpu_data_d;
   logic [CNT_W-1:0]         hit_q, hit_d;
   logic [CNT_W-1:0]         miss_q, miss_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         adr_q       <= '0;
         fill_cnt_q  <= '0;
         fill_buf_q  <= '0;
         cpu_ready_q <= 1'b0;
         cpu_data_q  <= '0;
         hit_q       <= '0;
         miss_q      <= '0;
      end else begin
         state_q     <= state_d;
         adr_q       <= adr_d;
         fill_cnt_q  <= fill_cnt_d;
         fill_buf_q  <= fill_buf_d;
         cpu_ready_q <= cpu_ready_d;
         cpu_data_q  <= cpu_data_d;
         hit_q       <= hit_d;
         miss_q      <= miss_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      adr_d       = adr_q;
      fill_cnt_d  = fill_cnt_q;
      fill_buf_d  = fill_buf_q;
      cpu_ready_d = 1'b0;
      cpu_data_d  = cpu_data_q;
      hit_d       = hit_q;
      miss_d      = miss_q;
      case (state_q)
         StIdle: begin
            if (bus.cpu_req) begin
               adr_d   = bus.cpu_adr;
               state_d = StLookup;
            end
         end
         StLookup: begin
            if (bus.cache_hit) begin
               cpu_data_d  = bus.cache_rdata;
               cpu_ready_d = 1'b1;
               if (hit_q != '1) hit_d = hit_q + 1'b1;
               state_d     = StIdle;
            end else begin
               if (miss_q != '1) miss_d = miss_q + 1'b1;
               fill_cnt_d = 2'd0;
               state_d    = StFill;
            end
         end
         StFill: begin
            // Fill is always in order from word 0; the requested word is picked in StWrite.
            if (bus.mem_ready) begin
               fill_buf_d[fill_cnt_q] = bus.mem_data;
               if (fill_cnt_q == 2'd3) state_d = StWrite;
               else fill_cnt_d = fill_cnt_q + 2'd1;
            end
         end
         StWrite: begin
            cpu_data_d  = fill_buf_q[adr_q[1:0]];
            cpu_ready_d = 1'b1;
            state_d     = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.cpu_busy     = (state_q != StIdle);
   assign bus.cpu_ready    = cpu_ready_q;
   assign bus.cpu_data     = cpu_data_q;
   assign bus.cache_adr    = adr_q;
   assign bus.cache_write  = (state_q == StWrite);
   assign bus.cache_wblock = fill_buf_q;
   assign bus.mem_req      = (state_q == StFill);
   assign bus.mem_adr      = {adr_q[ADDR_W-1:2], fill_cnt_q};
   assign bus.hit_count    = hit_q;
   assign bus.miss_count   = miss_q;

endmodule

// File: tb/tb_cache_fill_controller.sv
// Scoreboard bench for cache_fill_controller with behavioural cache and memory models.
module tb_cache_fill_controller;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cache_fill_controller_if bus ();

   cache_fill_controller dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [15:0] a);
      if (a[15:2] == 14'h048D) return 32'hA0 + {30'd0, a[1:0]};
      return {~a, a};
   endfunction

   assign bus.mem_data = mem_word(bus.mem_adr);

   // Direct-mapped cache model: 1024 blocks, tag kept as adr[15:12].
   logic [127:0] c_blk [1024];
   logic [3:0]   c_tag [1024];
   logic         c_vld [1024];
   logic [127:0] c_line;

   initial for (int i = 0; i < 1024; i++) c_vld[i] = 1'b0;

   assign c_line          = c_blk[bus.cache_adr[11:2]];
   assign bus.cache_hit   = c_vld[bus.cache_adr[11:2]] &&
                            (c_tag[bus.cache_adr[11:2]] == bus.cache_adr[15:12]);
   assign bus.cache_rdata = c_line[32*bus.cache_adr[1:0] +: 32];

   always @(posedge clk) begin
      if (bus.cache_write) begin
         c_blk[bus.cache_adr[11:2]] <= bus.cache_wblock;
         c_tag[bus.cache_adr[11:2]] <= bus.cache_adr[15:12];
         c_vld[bus.cache_adr[11:2]] <= 1'b1;
      end
   end

   // Memory responder and fill monitor, evaluated on the falling edge.
   logic [15:0] fill_base = '0;
   logic [1:0]  stall_word = '0;
   int          stall_left = 0;
   logic [1:0]  exp_idx = '0;
   int          accepted = 0;
   int          mem_cycles = 0;
   int          writes = 0;

   always @(negedge clk) begin
      if (rst) begin
         bus.mem_ready = 1'b0;
         exp_idx       = '0;
         accepted      = 0;
      end else begin
         bus.mem_ready = 1'b0;
         if (bus.mem_req) begin
            mem_cycles++;
            check_eq("mem_adr", bus.mem_adr, {fill_base[15:2], exp_idx});
            if (stall_left > 0 && bus.mem_adr[1:0] == stall_word) begin
               stall_left--;
            end else begin
               bus.mem_ready = 1'b1;
               exp_idx++;
               accepted++;
            end
         end
         if (bus.cache_write) begin
            writes++;
            check_eq("write_words", accepted, 4);
            check_eq("write_adr", bus.cache_adr, fill_base);
            check_eq("write_block", bus.cache_wblock,
                     {mem_word({fill_base[15:2], 2'd3}), mem_word({fill_base[15:2], 2'd2}),
                      mem_word({fill_base[15:2], 2'd1}), mem_word({fill_base[15:2], 2'd0})});
            accepted = 0;
         end
      end
   end

   logic [31:0] sb[$];
   logic [15:0] exp_hits = '0;
   logic [15:0] exp_misses = '0;

   // Call at a falling edge; returns at the falling edge where cpu_ready is seen.
   task automatic do_read(input logic [15:0] a, input bit hit, input int sw, input int sn);
      int          lat;
      int          m0;
      int          w0;
      logic [31:0] exp_data;
      #1;
      fill_base   = a;
      stall_word  = sw[1:0];
      stall_left  = sn;
      bus.cpu_req = 1'b1;
      bus.cpu_adr = a;
      sb.push_back(mem_word(a));
      if (hit) begin
         if (exp_hits != 16'hFFFF) exp_hits++;
      end else begin
         if (exp_misses != 16'hFFFF) exp_misses++;
      end
      m0 = mem_cycles;
      w0 = writes;
      @(posedge clk);
      #1 bus.cpu_req = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.cpu_ready && lat < 200);
      check_eq("latency", lat, hit ? 2 : 7 + sn);
      exp_data = sb.pop_front();
      check_eq("cpu_data", bus.cpu_data, exp_data);
      check_eq("busy_at_ready", bus.cpu_busy, 1'b0);
      check_eq("hit_count", bus.hit_count, exp_hits);
      check_eq("miss_count", bus.miss_count, exp_misses);
      check_eq("mem_cycles", mem_cycles - m0, hit ? 0 : 4 + sn);
      check_eq("cache_writes", writes - w0, hit ? 0 : 1);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      int w0;
      rst         = 1'b1;
      bus.cpu_req = 1'b0;
      bus.cpu_adr = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_busy", bus.cpu_busy, 1'b0);
      check_eq("rst_ready", bus.cpu_ready, 1'b0);
      check_eq("rst_data", bus.cpu_data, 32'h0);
      check_eq("rst_cache_adr", bus.cache_adr, 16'h0);
      check_eq("rst_write", bus.cache_write, 1'b0);
      check_eq("rst_wblock", bus.cache_wblock, 128'h0);
      check_eq("rst_mem_req", bus.mem_req, 1'b0);
      check_eq("rst_mem_adr", bus.mem_adr, 16'h0);
      check_eq("rst_hits", bus.hit_count, 16'h0);
      check_eq("rst_misses", bus.miss_count, 16'h0);
      #1 rst = 1'b0;
      @(negedge clk);

      do_read(16'h1234, 1'b0, 0, 0);   // cold miss
      do_read(16'h1236, 1'b1, 0, 0);   // hit
      do_read(16'h5234, 1'b0, 0, 0);   // conflict miss
      do_read(16'h1234, 1'b0, 0, 0);   // evicted block misses again
      do_read(16'h1235, 1'b1, 0, 0);   // back-to-back hit
      do_read(16'h2341, 1'b0, 2, 5);   // stall on word 2

      // Reset after word 1 of a fill has been accepted.
      @(negedge clk);
      #1;
      fill_base   = 16'h3000;
      stall_left  = 0;
      bus.cpu_req = 1'b1;
      bus.cpu_adr = 16'h3000;
      w0 = writes;
      @(posedge clk);
      #1 bus.cpu_req = 1'b0;
      n = 0;
      do begin
         @(posedge clk);
         #1 n++;
      end while (accepted < 2 && n < 50);
      check_eq("midfill_reached", accepted >= 2, 1'b1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_eq("midfill_busy", bus.cpu_busy, 1'b0);
      check_eq("midfill_mem_req", bus.mem_req, 1'b0);
      check_eq("midfill_hits", bus.hit_count, 16'h0);
      check_eq("midfill_misses", bus.miss_count, 16'h0);
      rst = 1'b0;
      exp_hits   = '0;
      exp_misses = '0;
      repeat (4) @(posedge clk);
      check_eq("midfill_no_write", writes - w0, 0);
      @(negedge clk);
      do_read(16'h3002, 1'b0, 0, 0);

      // Saturation of the hit counter.
      @(negedge clk);
      force dut.hit_q = 16'hFFFE;
      @(posedge clk);
      @(negedge clk);
      release dut.hit_q;
      exp_hits = 16'hFFFE;
      do_read(16'h3000, 1'b1, 0, 0);
      do_read(16'h3001, 1'b1, 0, 0);
      do_read(16'h3003, 1'b1, 0, 0);
      check_eq("hit_saturated", bus.hit_count, 16'hFFFF);
      check_eq("sb_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
